// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line constants and parity helper.
// The PARITY state only exists when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   MAX_DATA_BITS = 9;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } uart_state_e;
`endif

  // Callers zero-extend narrower words; the extra zeros do not change the XOR.
  function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] data,
                                       input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last
// cycle of each period with a one-cycle tick.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter, LSB first, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to add the parity_odd port and a parity bit per frame.
// Handshake: a word is taken on a rising edge where send && ready; ready is high
// only in IDLE, and send is ignored at all other times (nothing is queued).
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 send,
`ifdef UART_TX_PARITY_EN
  input  logic                 parity_odd,
`endif
  output logic                 ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           state_dbg
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  uart_state_e          state, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           bit_cnt, bit_cnt_d;
  logic                 tx_d, busy_d, done_d;
  logic                 accept, tick;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  assign ready     = (state == IDLE);
  assign accept    = ready && send;
  assign state_dbg = state;

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (state != IDLE),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shift_q <= '0;
      bit_cnt <= '0;
      tx      <= STOP_BIT;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      shift_q <= shift_d;
      bit_cnt <= bit_cnt_d;
      tx      <= tx_d;
      busy    <= busy_d;
      done    <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // tx is registered, so each bit is loaded on the tick that ends the previous one.
  always_comb begin
    state_d   = state;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt;
    tx_d      = tx;
    busy_d    = busy;
    done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    case (state)
      IDLE: begin
        if (send) begin
          state_d   = START;
          shift_d   = data_in;
          bit_cnt_d = '0;
          tx_d      = START_BIT;
          busy_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
          par_d     = parity_calc(MAX_DATA_BITS'(data_in), parity_odd);
`endif
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d   = STOP;
            tx_d      = STOP_BIT;
            bit_cnt_d = '0;
`endif
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt + 4'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d   = STOP;
          tx_d      = STOP_BIT;
          bit_cnt_d = '0;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (bit_cnt == LAST_STOP) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
